// File: rtl/instruction_cache_if.sv
// Fetch-side (PC/busyWait) and memory-side signals of the instruction cache.
// The slave modport is the cache; the master modport is the pipeline/memory environment.
interface instruction_cache_if;
  logic [31:0]  address;
  logic [31:0]  instruction;
  logic         busyWait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  modport slave (
    input  address, mem_readdata, mem_busywait,
    output instruction, busyWait, mem_read, mem_address
  );

  modport master (
    output address, mem_readdata, mem_busywait,
    input  instruction, busyWait, mem_read, mem_address
  );
endinterface

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache, 16-byte lines, combinational hit path,
// three-state block refill from instruction memory.
module instruction_cache #(
  parameter int INDEX_BITS = 3
) (
  input logic               CLK,
  input logic               RESET,
  instruction_cache_if.slave bus
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 28 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t                state;
  logic [LINES-1:0]      valid;
  logic [TAG_BITS-1:0]   tags [LINES];
  logic [127:0]          data [LINES];
  logic [127:0]          fill;
  logic                  mem_read_q;

  logic [1:0]            offset;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic [127:0]          line;
  logic                  hit;

  assign offset = bus.address[3:2];
  assign index  = bus.address[4 +: INDEX_BITS];
  assign tag    = bus.address[31 -: TAG_BITS];
  assign line   = data[index];
  assign hit    = valid[index] && (tags[index] == tag);

  always_comb begin
    bus.instruction = '0;
    if (hit && !RESET)
      bus.instruction = line[{offset, 5'd0} +: 32];
  end

  assign bus.busyWait    = RESET | (state != IDLE) | !hit;
  // Registered request is masked during reset so an abandoned fill drops mem_read at once.
  assign bus.mem_read    = mem_read_q & ~RESET;
  assign bus.mem_address = bus.address[31:4];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      valid      <= '0;
      mem_read_q <= 1'b0;
      fill       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            state      <= MEM_READ;
            mem_read_q <= 1'b1;
          end
        end
        MEM_READ: begin
          if (!bus.mem_busywait) begin
            fill       <= bus.mem_readdata;
            mem_read_q <= 1'b0;
            state      <= UPDATE;
          end
        end
        UPDATE: begin
          data[index]  <= fill;
          tags[index]  <= tag;
          valid[index] <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: per-cycle expectations derived from hit/miss rules and
// miss latency arithmetic, checked against the DUT on every falling edge.
module tb_instruction_cache;
  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  instruction_cache_if bus();

  instruction_cache #(.INDEX_BITS(3)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  typedef struct {
    logic        bw;
    logic        mr;
    logic [31:0] instr;
    logic [27:0] maddr;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          failures = 0;
  int          lat = 0;
  int          cnt = 0;
  bit          mvalid[8];
  logic [27:0] mblk[8];
  int          run = 0;
  int          last_run = 0;
  logic [27:0] last_maddr = '0;

  // Instruction memory contents: fixed words for two named blocks, hashed elsewhere.
  function automatic logic [31:0] mem_word(input logic [27:0] b, input int w);
    if (b == 28'h0) begin
      case (w)
        0:       return 32'h00000193;
        1:       return 32'h00000113;
        2:       return 32'h00000093;
        default: return 32'h00000013;
      endcase
    end
    if (b == 28'hFFFFFFF && w == 3) return 32'hDEADBEEF;
    return ({4'h0, b} * 32'h9E3779B1) ^ (32'(w) * 32'h85EBCA6B) ^ 32'h5BD1E995;
  endfunction

  function automatic logic [127:0] mem_block(input logic [27:0] b);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = mem_word(b, i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Memory responder: busy for `lat` cycles after mem_read rises, then data valid.
  always @(negedge CLK) begin
    if (bus.mem_read) begin
      bus.mem_busywait = (cnt < lat);
      cnt++;
    end else begin
      cnt = 0;
      bus.mem_busywait = 1'b0;
    end
    bus.mem_readdata = mem_block(bus.mem_address);
  end

  always @(negedge CLK) begin
    exp_t e;
    if (RESET) run = 0;
    else if (bus.busyWait) run++;
    else if (run > 0) begin
      last_run = run;
      run = 0;
    end
    if (bus.mem_read) last_maddr = bus.mem_address;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("busyWait", bus.busyWait, e.bw);
      chk("mem_read", bus.mem_read, e.mr);
      chk("instruction", bus.instruction, e.instr);
      if (e.mr) chk("mem_address", bus.mem_address, e.maddr);
    end
  end

  task automatic step(input exp_t e);
    expq.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int n);
    exp_t e;
    e = '{1'b1, 1'b0, 32'h0, 28'h0};
    RESET = 1'b1;
    repeat (n) step(e);
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
  endtask

  // One fetch: hit costs one cycle; miss costs L+3 stall cycles then a hit cycle.
  // abort_at >= 0 asserts RESET during that stall cycle and abandons the fill.
  task automatic fetch(input logic [31:0] a, input int L, input int abort_at);
    logic [27:0] b;
    int          idx;
    exp_t        e;
    b   = a[31:4];
    idx = int'(a[6:4]);
    bus.address = a;
    lat = L;
    if (mvalid[idx] && mblk[idx] == b) begin
      e = '{1'b0, 1'b0, mem_word(b, int'(a[3:2])), 28'h0};
      step(e);
      return;
    end
    for (int i = 0; i <= L + 2; i++) begin
      e.bw    = 1'b1;
      e.mr    = (i >= 1 && i <= L + 1);
      e.instr = 32'h0;
      e.maddr = b;
      if (i == abort_at) begin
        RESET = 1'b1;
        e.mr  = 1'b0;
        step(e);
        RESET = 1'b0;
        for (int k = 0; k < 8; k++) mvalid[k] = 1'b0;
        return;
      end
      step(e);
    end
    mvalid[idx] = 1'b1;
    mblk[idx]   = b;
    e = '{1'b0, 1'b0, mem_word(b, int'(a[3:2])), 28'h0};
    step(e);
  endtask

  logic [24:0] tag_pool[4];

  initial begin
    logic [31:0] a;
    int          L;
    int          ab;
    tag_pool[0] = 25'h0;
    tag_pool[1] = 25'h1;
    tag_pool[2] = 25'h1ABCDE;
    tag_pool[3] = 25'h1FFFFFF;
    RESET = 1'b1;
    bus.address = 32'h0;
    bus.mem_busywait = 1'b0;
    bus.mem_readdata = '0;
    @(posedge CLK);
    #1;
    do_reset(2);

    fetch(32'h0, 5, -1);
    chk("cold_stall_len", last_run, 8);
    chk("cold_maddr", last_maddr, 28'h0);
    chk("cold_word0", bus.instruction, 32'h00000193);

    fetch(32'h4, 0, -1);
    chk("hit_word1", bus.instruction, 32'h00000113);
    fetch(32'h8, 0, -1);
    chk("hit_word2", bus.instruction, 32'h00000093);
    fetch(32'hC, 0, -1);
    chk("hit_word3", bus.instruction, 32'h00000013);

    fetch(32'h80, 3, -1);
    chk("conflict_maddr", last_maddr, 28'h8);
    chk("conflict_len", last_run, 6);
    fetch(32'h0, 2, -1);
    chk("conflict_back_len", last_run, 5);

    do_reset(1);
    fetch(32'hFFFFFFFC, 0, -1);
    chk("pc_reset_len", last_run, 3);
    chk("pc_reset_maddr", last_maddr, 28'hFFFFFFF);
    chk("pc_reset_word", bus.instruction, 32'hDEADBEEF);

    fetch(32'h40, 5, 3);
    fetch(32'h40, 1, -1);
    chk("abort_remiss_len", last_run, 4);

    fetch(32'h12345678, 20, -1);
    chk("stall_len", last_run, 23);
    chk("stall_maddr", last_maddr, 28'h1234567);

    repeat (300) begin
      a  = {tag_pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
      L  = int'($urandom_range(0, 4));
      ab = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, L + 2)) : -1;
      fetch(a, L, ab);
    end

    repeat (3) begin
      @(posedge CLK);
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
